result_display_decoder: RTL and testbench

//  Sink end of the calculator's 11-bit result bus. Accepts one result word
//  (bit 10 = overflow, bits 9:0 = two's-complement value) per valid/ready handshake.

---
 rtl/result_display_decoder_pkg.sv | 51 +++++
 rtl/result_display_decoder_seg7_encode.sv | 30 +++
 rtl/result_display_decoder.sv | 187 ++++++++++++++++++
 tb/tb_result_display_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_display_decoder_pkg.sv
// Shared definitions for the result display decoder: bus widths, FSM states,
// glyph codes and the double-dabble nibble correction.
package result_display_decoder_pkg;

    localparam int DATA_W     = 11;
    localparam int VAL_W      = 10;
    localparam int OVF_BIT    = 10;
    localparam int BCD_W      = 12;
    localparam int STEP_W     = 4;
    localparam int NUM_DIGITS = 4;
    localparam int SEG_W      = 7;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    // Codes 0-9 are the decimal digits themselves, so a BCD nibble casts directly.
    typedef enum logic [3:0] {
        GLYPH_0     = 4'd0,
        GLYPH_1     = 4'd1,
        GLYPH_2     = 4'd2,
        GLYPH_3     = 4'd3,
        GLYPH_4     = 4'd4,
        GLYPH_5     = 4'd5,
        GLYPH_6     = 4'd6,
        GLYPH_7     = 4'd7,
        GLYPH_8     = 4'd8,
        GLYPH_9     = 4'd9,
        GLYPH_MINUS = 4'd10,
        GLYPH_E     = 4'd11,
        GLYPH_R     = 4'd12,
        GLYPH_BLANK = 4'd15
    } glyph_t;

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return adj;
    endfunction

    function automatic glyph_t to_glyph(input logic [3:0] digit, input logic blank);
        return blank ? GLYPH_BLANK : glyph_t'(digit);
    endfunction

endpackage

// File: rtl/result_display_decoder_seg7_encode.sv
// Glyph code to active-high seven-segment pattern, bit order {g,f,e,d,c,b,a}.
// Purely combinational; display polarity is applied by the caller.
module seg7_encode
    import result_display_decoder_pkg::*;
(
    input  glyph_t           glyph_i,
    output logic [SEG_W-1:0] pattern_o
);

    always_comb begin
        pattern_o = 7'b0000000;
        unique case (glyph_i)
            GLYPH_0:     pattern_o = 7'b0111111;
            GLYPH_1:     pattern_o = 7'b0000110;
            GLYPH_2:     pattern_o = 7'b1011011;
            GLYPH_3:     pattern_o = 7'b1001111;
            GLYPH_4:     pattern_o = 7'b1100110;
            GLYPH_5:     pattern_o = 7'b1101101;
            GLYPH_6:     pattern_o = 7'b1111101;
            GLYPH_7:     pattern_o = 7'b0000111;
            GLYPH_8:     pattern_o = 7'b1111111;
            GLYPH_9:     pattern_o = 7'b1101111;
            GLYPH_MINUS: pattern_o = 7'b1000000;
            GLYPH_E:     pattern_o = 7'b1111001;
            GLYPH_R:     pattern_o = 7'b1010000;
            default:     pattern_o = 7'b0000000;
        endcase
    end

endmodule

// File: rtl/result_display_decoder.sv
// Result bus sink: converts a signed 10-bit word to sign + 3 BCD digits by
// iterative double-dabble and scans the result onto a 4-digit 7-seg display.
module result_display_decoder
    import result_display_decoder_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              busy,
    output logic [SEG_W-1:0]  seg,
    output logic [3:0]        an
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t                         state_q, state_d;
    logic                           sign_q, sign_d;
    logic [VAL_W-1:0]               mag_q, mag_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic [STEP_W-1:0]              step_q, step_d;
    glyph_t [NUM_DIGITS-1:0]        digit_q, digit_d;

    logic [DIV_W-1:0]               div_q, div_d;
    logic [1:0]                     idx_q, idx_d;
    logic [SEG_W-1:0]               seg_q, seg_d;
    logic [3:0]                     an_q, an_d;

    logic                           accept;
    logic                           accept_val;
    logic                           last_step;
    logic [VAL_W-1:0]               in_mag;
    logic [BCD_W-1:0]               bcd_adj;
    logic [BCD_W-1:0]               bcd_shift;
    logic [3:0]                     hund, tens, ones;
    logic                           wrap;
    logic [SEG_W-1:0]               pattern;

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    assign last_step  = (state_q == CONV) && (step_q == STEP_W'(VAL_W - 1));
    assign accept     = in_valid && in_ready;
    assign accept_val = accept && !in_data[OVF_BIT];

    // -512 negates to itself, which reads correctly as unsigned 512.
    assign in_mag = in_data[VAL_W-1] ? (~in_data[VAL_W-1:0] + VAL_W'(1)) : in_data[VAL_W-1:0];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values together.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves the signal unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_val) state_d = CONV;
            CONV:    if (last_step)  state_d = accept_val ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Ready also on the final step so a held word is taken on the finishing edge.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: in_ready = 1'b1;
            CONV: begin
                busy     = 1'b1;
                in_ready = last_step;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Double-dabble datapath and display registers
    // ------------------------------------------------------------------
    assign bcd_adj   = bcd_adjust(bcd_q);
    assign bcd_shift = {bcd_adj[BCD_W-2:0], mag_q[VAL_W-1]};
    assign hund      = bcd_shift[11:8];
    assign tens      = bcd_shift[7:4];
    assign ones      = bcd_shift[3:0];

    always_comb begin
        sign_d  = sign_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        step_d  = step_q;
        digit_d = digit_q;

        if (state_q == CONV) begin
            bcd_d  = bcd_shift;
            mag_d  = {mag_q[VAL_W-2:0], 1'b0};
            step_d = step_q + 1'b1;
            if (last_step) begin
                digit_d[3] = sign_q ? GLYPH_MINUS : GLYPH_BLANK;
                digit_d[2] = to_glyph(hund, hund == 4'd0);
                digit_d[1] = to_glyph(tens, (hund == 4'd0) && (tens == 4'd0));
                digit_d[0] = to_glyph(ones, 1'b0);
            end
        end

        // A word accepted on the finishing edge supersedes the finished result.
        if (accept) begin
            if (in_data[OVF_BIT]) begin
                digit_d[3] = GLYPH_BLANK;
                digit_d[2] = GLYPH_E;
                digit_d[1] = GLYPH_R;
                digit_d[0] = GLYPH_R;
            end else begin
                sign_d = in_data[VAL_W-1];
                mag_d  = in_mag;
                bcd_d  = '0;
                step_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_q  <= 1'b0;
            mag_q   <= '0;
            bcd_q   <= '0;
            step_q  <= '0;
            // NOTE: the display digits are plain flops, not a RAM, so they reset like any register.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= GLYPH_BLANK;
            end
        end else begin
            sign_q  <= sign_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            step_q  <= step_d;
            digit_q <= digit_d;
        end
    end

    // ------------------------------------------------------------------
    // Free-running digit scan
    // ------------------------------------------------------------------
    assign wrap = (div_q == DIV_W'(SCAN_DIV - 1));

    seg7_encode u_seg7_encode (
        .glyph_i   (digit_q[idx_d]),
        .pattern_o (pattern)
    );

    always_comb begin
        div_d = wrap ? '0 : div_q + 1'b1;
        idx_d = wrap ? idx_q + 2'd1 : idx_q;
        seg_d = seg_q;
        an_d  = an_q;
        if (wrap) begin
            seg_d = pattern ^ {SEG_W{SEG_ACTIVE_LOW}};
            an_d  = (4'b0001 << idx_d) ^ {4{SEG_ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            idx_q <= '0;
            seg_q <= {SEG_W{SEG_ACTIVE_LOW}};
            an_q  <= 4'b0001 ^ {4{SEG_ACTIVE_LOW}};
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_result_display_decoder.sv
// Self-checking bench: a cycle model derived from decimal arithmetic is
// compared against the DUT every cycle, plus hand-computed scan literals.
module tb_result_display_decoder;

    localparam int SCAN_DIV = 4;

    localparam logic [3:0] G_MINUS = 4'd10;
    localparam logic [3:0] G_E     = 4'd11;
    localparam logic [3:0] G_R     = 4'd12;
    localparam logic [3:0] G_BLANK = 4'd13;

    typedef struct packed {
        logic [15:0] disp;   // shown glyphs, digit i at [4*i +: 4]
        logic [15:0] pend;   // result waiting for the conversion to finish
        logic [7:0]  left;   // edges until the pending result is shown
        logic [7:0]  div;
        logic [1:0]  idx;
        logic [6:0]  seg;
        logic [3:0]  an;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    model_t m;
    logic   m_valid = 1'b0;
    int     n_cmp = 0;
    int     n_fail = 0;

    result_display_decoder #(
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph_pat(input logic [3:0] g);
        case (g)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            G_MINUS: return 7'b1000000;
            G_E:     return 7'b1111001;
            G_R:     return 7'b1010000;
            default: return 7'b0000000;
        endcase
    endfunction

    // Conversion takes ten edges; the decimal result is computed directly here.
    function automatic model_t model_step(input model_t cur, input logic r,
                                          input logic v, input logic [10:0] d);
        model_t nxt;
        int     val;
        int     mag;
        nxt = cur;
        if (r) begin
            nxt.left = 8'd0;
            nxt.div  = 8'd0;
            nxt.idx  = 2'd0;
            nxt.seg  = 7'h7F;
            nxt.an   = 4'b1110;
            nxt.disp = {4{G_BLANK}};
            nxt.pend = {4{G_BLANK}};
            return nxt;
        end
        if (cur.div == 8'(SCAN_DIV - 1)) begin
            nxt.div = 8'd0;
            nxt.idx = cur.idx + 2'd1;
            nxt.seg = ~glyph_pat(cur.disp[4*nxt.idx +: 4]);
            nxt.an  = 4'hF;
            nxt.an[nxt.idx] = 1'b0;
        end else begin
            nxt.div = cur.div + 8'd1;
        end
        if (cur.left != 8'd0) begin
            nxt.left = cur.left - 8'd1;
            if (nxt.left == 8'd0) nxt.disp = cur.pend;
        end
        if (v && cur.left <= 8'd1) begin
            if (d[10]) begin
                nxt.disp = {G_BLANK, G_E, G_R, G_R};
            end else begin
                val = $signed(d[9:0]);
                mag = (val < 0) ? -val : val;
                nxt.pend[15:12] = (val < 0) ? G_MINUS : G_BLANK;
                nxt.pend[11:8]  = (mag >= 100) ? 4'(mag / 100) : G_BLANK;
                nxt.pend[7:4]   = (mag >= 10) ? 4'((mag / 10) % 10) : G_BLANK;
                nxt.pend[3:0]   = 4'(mag % 10);
                nxt.left        = 8'd10;
            end
        end
        return nxt;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, rst, in_valid, in_data);
        if (rst) m_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("in_ready", in_ready, m.left <= 8'd1);
            check("busy", busy, m.left != 8'd0);
            check("seg", seg, m.seg);
            check("an", an, m.an);
        end
    end

    // Called at a negedge: presents a word and drops valid after the accept edge.
    task automatic send(input logic [10:0] d);
        int guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (12 + 5 * SCAN_DIV) @(negedge clk);
    endtask

    task automatic wait_an(input logic [3:0] target, input logic [6:0] exp_seg, input string name);
        int guard = 0;
        while (an !== target && guard < 4 * SCAN_DIV + 4) begin
            @(negedge clk);
            guard++;
        end
        if (an !== target) check({name, "_timeout"}, an, target);
        else check(name, seg, exp_seg);
    endtask

    initial begin
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1111111);
        check("rst_ready", in_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-conversion abandons the word; display stays blank
        send(11'h07B);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        rst = 1'b0;
        settle();
        wait_an(4'b1011, 7'b1111111, "abort_blank_d2");
        wait_an(4'b1110, 7'b1111111, "abort_blank_d0");

        // +123: busy for ten cycles, then {BLANK,1,2,3}
        send(11'h07B);
        k = 0;
        while (busy && k < 20) begin
            k++;
            @(negedge clk);
        end
        check("busy_cycles_123", k, 10);
        check("model_123_d3", glyph_pat(m.disp[15:12]), 7'b0000000);
        check("model_123_d2", glyph_pat(m.disp[11:8]), 7'b0000110);
        check("model_123_d1", glyph_pat(m.disp[7:4]), 7'b1011011);
        check("model_123_d0", glyph_pat(m.disp[3:0]), 7'b1001111);
        settle();
        wait_an(4'b1011, 7'b1111001, "p123_d2");
        wait_an(4'b1101, 7'b0100100, "p123_d1");
        wait_an(4'b1110, 7'b0110000, "p123_d0");
        wait_an(4'b0111, 7'b1111111, "p123_d3");

        // -512 -> {-,5,1,2}
        send(11'h200);
        settle();
        check("model_m512_d2", glyph_pat(m.disp[11:8]), 7'b1101101);
        wait_an(4'b0111, 7'b0111111, "m512_d3");
        wait_an(4'b1011, 7'b0010010, "m512_d2");
        wait_an(4'b1101, 7'b1111001, "m512_d1");
        wait_an(4'b1110, 7'b0100100, "m512_d0");

        // -1 -> {-,BLANK,BLANK,1}
        send(11'h3FF);
        settle();
        wait_an(4'b0111, 7'b0111111, "m1_d3");
        wait_an(4'b1011, 7'b1111111, "m1_d2");
        wait_an(4'b1101, 7'b1111111, "m1_d1");
        wait_an(4'b1110, 7'b1111001, "m1_d0");

        // 0 -> {BLANK,BLANK,BLANK,0}
        send(11'h000);
        settle();
        wait_an(4'b1101, 7'b1111111, "z_d1");
        wait_an(4'b1110, 7'b1000000, "z_d0");

        // +10 -> {BLANK,BLANK,1,0}
        send(11'h00A);
        settle();
        wait_an(4'b1011, 7'b1111111, "p10_d2");
        wait_an(4'b1101, 7'b1111001, "p10_d1");
        wait_an(4'b1110, 7'b1000000, "p10_d0");

        // Overflow: Err shown, no conversion, stays ready
        send(11'h400);
        check("ovf_ready", in_ready, 1'b1);
        check("ovf_busy", busy, 1'b0);
        settle();
        wait_an(4'b1011, 7'b0000110, "ovf_d2");
        wait_an(4'b1101, 7'b0101111, "ovf_d1");
        wait_an(4'b1110, 7'b0101111, "ovf_d0");
        wait_an(4'b0111, 7'b1111111, "ovf_d3");

        // Back-to-back: second word held by upstream, taken on the finishing edge
        check("b2b_ready0", in_ready, 1'b1);
        in_data  = 11'h001;
        in_valid = 1'b1;
        @(negedge clk);
        in_data = 11'h002;
        k = 1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("b2b_accept_gap", k, 10);
        @(negedge clk);
        in_valid = 1'b0;
        check("b2b_busy_after", busy, 1'b1);
        settle();
        wait_an(4'b1110, 7'b0100100, "b2b_d0");
        wait_an(4'b1101, 7'b1111111, "b2b_d1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
